// File: rtl/audio_capture_pkg.sv
// audio_capture_pkg: shared defaults, capture FSM states and channel constant for audio_capture
package audio_capture_pkg;
  localparam int BUFFER_ADDR_BITS_DEF = 9;
  localparam int SAMPLE_BITS_DEF = 16;
  localparam logic [7:0] MONO_CHANNELS = 8'd1;
  typedef enum logic [2:0] {IDLE, SYNC, RX_L, WR_L, RX_R, WR_R} cap_state_t;
endpackage

// File: rtl/audio_capture_i2s_rx_deserializer.sv
// i2s_rx_deserializer: synchronizes the codec I2S pins and shifts in one MSB-first word per slot
module i2s_rx_deserializer
  import audio_capture_pkg::*;
#(
  parameter int SAMPLE_BITS = SAMPLE_BITS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic bclk,
  input  logic lrck,
  input  logic dat,
  output logic word_valid,
  output logic word_right,
  output logic lr_edge,
  output logic lr_fall,
  output logic [SAMPLE_BITS-1:0] word
);
  localparam int CW = $clog2(SAMPLE_BITS + 2);
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_BITS);
  localparam logic [CW-1:0] DONE = CW'(SAMPLE_BITS + 1);
  logic [2:0] bclk_s, lrck_s;
  logic [1:0] dat_s;
  logic [CW-1:0] cnt;
  logic rise;
  assign rise = bclk_s[1] & ~bclk_s[2];
  assign lr_edge = lrck_s[1] ^ lrck_s[2];
  assign lr_fall = lrck_s[2] & ~lrck_s[1];
  // cnt 0 marks the I2S delay bit; DONE parks the counter until the next slot
  always_ff @(posedge clk) begin
    if (rst) begin
      bclk_s <= '0;
      lrck_s <= '0;
      dat_s <= '0;
      cnt <= DONE;
      word <= '0;
      word_valid <= 1'b0;
      word_right <= 1'b0;
    end else begin
      bclk_s <= {bclk_s[1:0], bclk};
      lrck_s <= {lrck_s[1:0], lrck};
      dat_s <= {dat_s[0], dat};
      word_valid <= 1'b0;
      if (lr_edge) begin
        cnt <= '0;
        word_right <= lrck_s[1];
      end else if (rise && cnt != DONE) begin
        cnt <= cnt + 1'b1;
        if (cnt != '0) word <= {word[SAMPLE_BITS-2:0], dat_s[1]};
        if (cnt == LAST) word_valid <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/audio_capture.sv
// audio_capture: I2S ADC capture packed as LE bytes into ping-pong RAM halves.
// Define CAPTURE_PEAK_METER_EN to add the per-half peak meter and capture_peak_o.
module audio_capture
  import audio_capture_pkg::*;
#(
  parameter int BUFFER_ADDR_BITS = BUFFER_ADDR_BITS_DEF,
  parameter int SAMPLE_BITS = SAMPLE_BITS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic capture_enable_i,
  input  logic [7:0] capture_channels_i,
  input  logic aud_bclk_i,
  input  logic aud_adclrck_i,
  input  logic aud_adcdat_i,
  output logic [BUFFER_ADDR_BITS-1:0] capture_buffer_addr_o,
  output logic capture_buffer_wren_o,
  output logic [7:0] capture_buffer_data_o,
  output logic capture_buffer_sel_o,
  output logic capture_buffer_filled_o,
  input  logic capture_buffer_taken_i,
  output logic capture_overrun_o
`ifdef CAPTURE_PEAK_METER_EN
  ,
  output logic [7:0] capture_peak_o
`endif
);
  logic word_valid, word_right, lr_edge, lr_fall, mono, last_byte;
  logic [SAMPLE_BITS-1:0] word;
  logic [7:0] hi_byte;
  cap_state_t state;
  assign mono = capture_channels_i == MONO_CHANNELS;
  assign last_byte = capture_buffer_wren_o && (&capture_buffer_addr_o);
  i2s_rx_deserializer #(.SAMPLE_BITS(SAMPLE_BITS)) u_rx (
    .clk(clk),
    .rst(rst),
    .bclk(aud_bclk_i),
    .lrck(aud_adclrck_i),
    .dat(aud_adcdat_i),
    .word_valid(word_valid),
    .word_right(word_right),
    .lr_edge(lr_edge),
    .lr_fall(lr_fall),
    .word(word)
  );
  // a take coinciding with half completion is honoured first, so the swap still happens
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      capture_buffer_addr_o <= '0;
      capture_buffer_wren_o <= 1'b0;
      capture_buffer_data_o <= '0;
      capture_buffer_sel_o <= 1'b0;
      capture_buffer_filled_o <= 1'b0;
      capture_overrun_o <= 1'b0;
      hi_byte <= '0;
    end else begin
      capture_buffer_wren_o <= 1'b0;
      if (capture_buffer_wren_o) capture_buffer_addr_o <= capture_buffer_addr_o + 1'b1;
      if (last_byte && (!capture_buffer_filled_o || capture_buffer_taken_i)) begin
        capture_buffer_sel_o <= ~capture_buffer_sel_o;
        capture_buffer_filled_o <= 1'b1;
      end else if (last_byte) capture_overrun_o <= 1'b1;
      else if (capture_buffer_taken_i) capture_buffer_filled_o <= 1'b0;
      case (state)
        IDLE: if (capture_enable_i) begin
          state <= SYNC;
          capture_buffer_addr_o <= '0;
        end
        SYNC: state <= !capture_enable_i ? IDLE : lr_fall ? RX_L : SYNC;
        RX_L: if (word_valid && !word_right) begin
          capture_buffer_wren_o <= 1'b1;
          capture_buffer_data_o <= word[7:0];
          hi_byte <= word[15:8];
          state <= WR_L;
        end
        WR_L: if (lr_edge) state <= SYNC;
        else begin
          capture_buffer_wren_o <= 1'b1;
          capture_buffer_data_o <= hi_byte;
          state <= mono ? SYNC : RX_R;
        end
        RX_R: if (word_valid && word_right) begin
          capture_buffer_wren_o <= 1'b1;
          capture_buffer_data_o <= word[7:0];
          hi_byte <= word[15:8];
          state <= WR_R;
        end
        WR_R: if (lr_edge) state <= SYNC;
        else begin
          capture_buffer_wren_o <= 1'b1;
          capture_buffer_data_o <= hi_byte;
          state <= capture_enable_i ? RX_L : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef CAPTURE_PEAK_METER_EN
  logic accept;
  logic [SAMPLE_BITS-1:0] neg, mag, peak_run;
  assign accept = word_valid && ((state == RX_L && !word_right) || (state == RX_R && word_right));
  assign neg = ~word + 1'b1;
  assign mag = !word[SAMPLE_BITS-1] ? word : neg[SAMPLE_BITS-1] ? {1'b0, {(SAMPLE_BITS-1){1'b1}}} : neg;
  always_ff @(posedge clk) begin
    if (rst) begin
      peak_run <= '0;
      capture_peak_o <= '0;
    end else if (last_byte) begin
      capture_peak_o <= peak_run[SAMPLE_BITS-1 -: 8];
      peak_run <= '0;
    end else if (accept && mag > peak_run) peak_run <= mag;
  end
`endif
endmodule

// File: tb/tb_audio_capture.sv
// tb_audio_capture: directed bench for audio_capture driven by a behavioural I2S ADC source
module tb_audio_capture;
  localparam int AB = 5;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic taken = 1'b0;
  logic [7:0] chans = 8'd2;
  logic bclk, lrck, dat;
  logic [AB-1:0] addr;
  logic wren, sel, filled, overrun;
  logic [7:0] data;
`ifdef CAPTURE_PEAK_METER_EN
  logic [7:0] peak;
`endif
  logic [15:0] l_word = 16'h1234;
  logic [15:0] r_word = 16'hABCD;
  logic [7:0] mem [2][2**AB];
  int nwr = 0;
  int checks = 0;
  int failures = 0;

  audio_capture #(.BUFFER_ADDR_BITS(AB)) dut (
    .clk(clk),
    .rst(rst),
    .capture_enable_i(en),
    .capture_channels_i(chans),
    .aud_bclk_i(bclk),
    .aud_adclrck_i(lrck),
    .aud_adcdat_i(dat),
    .capture_buffer_addr_o(addr),
    .capture_buffer_wren_o(wren),
    .capture_buffer_data_o(data),
    .capture_buffer_sel_o(sel),
    .capture_buffer_filled_o(filled),
    .capture_buffer_taken_i(taken),
    .capture_overrun_o(overrun)
`ifdef CAPTURE_PEAK_METER_EN
    ,
    .capture_peak_o(peak)
`endif
  );

  always #5 clk = ~clk;

  // 20-bit slots, BCLK 86 ns against a 10 ns clk; LRCK and data change on BCLK fall
  initial begin : i2s_src
    logic [15:0] w;
    bclk = 1'b0;
    lrck = 1'b1;
    dat = 1'b0;
    forever for (int c = 0; c < 2; c++) begin
      w = c[0] ? r_word : l_word;
      for (int b = 0; b < 20; b++) begin
        bclk = 1'b0;
        lrck = c[0];
        dat = (b >= 1 && b <= 16) ? w[15] : 1'b0;
        if (b >= 1) w = w << 1;
        #43 bclk = 1'b1;
        #43;
      end
    end
  end

  always @(posedge clk) if (wren) begin
    mem[sel][addr] <= data;
    nwr <= nwr + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_wr(input int n, input int base, input int lim);
    for (int i = 0; i < lim && nwr - base < n; i++) @(negedge clk);
  endtask

  task automatic wait_wren(input int lim);
    for (int i = 0; i < lim && !wren; i++) @(negedge clk);
  endtask

  task automatic chk_half(input string tag, input logic h, input logic [31:0] pat, input int period);
    int bad;
    logic [7:0] e;
    bad = 0;
    for (int i = 0; i < 2**AB; i++) begin
      e = pat[8*(i % period) +: 8];
      if (mem[h][i] !== e) bad++;
    end
    chk(tag, bad, 0);
  endtask

  initial begin : main
    int base;
    cyc(3);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_wren", 32'(wren), 0);
    chk("rst_data", 32'(data), 0);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_filled", 32'(filled), 0);
    chk("rst_overrun", 32'(overrun), 0);
`ifdef CAPTURE_PEAK_METER_EN
    chk("rst_peak", 32'(peak), 0);
`endif
    rst = 1'b0;
    base = nwr;
    en = 1'b1;
    wait_wr(32, base, 6000);
    chk("st1_bytes", nwr - base, 32);
    chk("st1_filled", 32'(filled), 1);
    chk("st1_sel", 32'(sel), 1);
    chk("st1_overrun", 32'(overrun), 0);
    chk_half("st1_data", 1'b0, 32'hABCD1234, 4);
    wait_wr(64, base, 4000);
    chk("st2_bytes", nwr - base, 64);
    chk("ovr_set", 32'(overrun), 1);
    chk("ovr_sel", 32'(sel), 1);
    chk("ovr_filled", 32'(filled), 1);
    chk_half("st2_data", 1'b1, 32'hABCD1234, 4);
    taken = 1'b1;
    cyc(1);
    taken = 1'b0;
    chk("take_filled", 32'(filled), 0);
    chk("take_overrun", 32'(overrun), 1);
    chk("take_sel", 32'(sel), 1);
    en = 1'b0;
    cyc(1000);
    chans = 8'd1;
    l_word = 16'h00FF;
    r_word = 16'h5A5A;
    base = nwr;
    en = 1'b1;
    wait_wr(32, base, 8000);
    chk("mono_bytes", nwr - base, 32);
    chk("mono_filled", 32'(filled), 1);
    chk("mono_sel", 32'(sel), 0);
    chk_half("mono_data", 1'b1, 32'h000000FF, 2);
    taken = 1'b1;
    cyc(1);
    taken = 1'b0;
    chk("mono_take", 32'(filled), 0);
    en = 1'b0;
    cyc(1000);
    chans = 8'd2;
    l_word = 16'h5678;
    r_word = 16'h9ABC;
    base = nwr;
    en = 1'b1;
    wait_wr(1, base, 2000);
    cyc(2);
    en = 1'b0;
    cyc(1000);
    chk("drop_bytes", nwr - base, 4);
    chk("drop_b0", 32'(mem[0][0]), 32'h78);
    chk("drop_b1", 32'(mem[0][1]), 32'h56);
    chk("drop_b2", 32'(mem[0][2]), 32'hBC);
    chk("drop_b3", 32'(mem[0][3]), 32'h9A);
    en = 1'b1;
    wait_wren(2000);
    chk("reen_wren", 32'(wren), 1);
    chk("reen_addr", 32'(addr), 0);
    chk("reen_data", 32'(data), 32'h78);
    cyc(1000);
    rst = 1'b1;
    cyc(1);
    chk("rst2_addr", 32'(addr), 0);
    chk("rst2_wren", 32'(wren), 0);
    chk("rst2_data", 32'(data), 0);
    chk("rst2_sel", 32'(sel), 0);
    chk("rst2_filled", 32'(filled), 0);
    chk("rst2_overrun", 32'(overrun), 0);
`ifdef CAPTURE_PEAK_METER_EN
    chk("rst2_peak", 32'(peak), 0);
`endif
    rst = 1'b0;
    base = nwr;
    wait_wren(2000);
    chk("post_rst_addr", 32'(addr), 0);
    chk("post_rst_data", 32'(data), 32'h78);
    wait_wr(32, base, 6000);
    chk("post_rst_bytes", nwr - base, 32);
    chk("post_rst_filled", 32'(filled), 1);
    chk("post_rst_sel", 32'(sel), 1);
    chk("post_rst_overrun", 32'(overrun), 0);
    chk_half("post_rst_data", 1'b0, 32'h9ABC5678, 4);
`ifdef CAPTURE_PEAK_METER_EN
    chk("peak_a", 32'(peak), 32'h65);
    l_word = 16'h8000;
    r_word = 16'h4000;
    taken = 1'b1;
    cyc(1);
    taken = 1'b0;
    wait_wr(64, base, 4000);
    chk("peak_b", 32'(peak), 32'h7F);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/audio_capture.md
# audio_capture

Line-in recording front end: the reverse path of the playback codec interface. Deserializes the codec ADC's I2S stream and packs samples as little-endian bytes into one half of the shared dual-port RAM. When a half is full it swaps halves and raises a filled flag for the downstream SD block writer. Sits between the codec pins (ADCDAT plus the BCLK/ADCLRCK generated by the codec block) and the RAM write port.

## Interface
- BUFFER_ADDR_BITS, 9, byte address width of one buffer half (512 B = one SD block)
- SAMPLE_BITS, 16, bits captured per channel, MSB first
- clk  in  1  system clock (200 MHz)
- rst  in  1  synchronous, active-high reset
- capture_enable_i  in  1  level; start/stop recording
- capture_channels_i  in  8  1 = mono (left only); any other value = stereo
- aud_bclk_i, aud_adclrck_i, aud_adcdat_i  in  1 each  codec serial clock, frame clock and data; asynchronous to clk
- capture_buffer_addr_o  out  BUFFER_ADDR_BITS  RAM byte write address within the active half
- capture_buffer_wren_o  out  1  RAM write strobe, one byte per asserted cycle
- capture_buffer_data_o  out  8  RAM write data
- capture_buffer_sel_o  out  1  half currently being written; the consumer reads !sel
- capture_buffer_filled_o  out  1  completed half is ready for the consumer
- capture_buffer_taken_i  in  1  consumer has drained the filled half (pulse or level)
- capture_overrun_o  out  1  sticky; a half completed while the previous one was not yet taken
- capture_peak_o  out  8  peak level, only present with CAPTURE_PEAK_METER_EN

## Operation
- Input conditioning:
  - 2-FF synchronizer on each aud_* input.
  - Edge detect on the synchronized BCLK and ADCLRCK.
  - Data is sampled on synchronized BCLK rising edges.
- I2S framing:
  - ADCLRCK low = left, high = right.
  - The first BCLK rise after an ADCLRCK edge is the delay bit and is ignored.
  - The next SAMPLE_BITS rises shift in MSB first; further bits in the slot are ignored.
- States:
  - IDLE: enable low.
  - SYNC: wait for an ADCLRCK falling edge, which marks the start of the left slot.
  - RX_L, WR_L: receive the left word, then write its two bytes.
  - RX_R, WR_R: receive the right word, then write its two bytes.
  - Transitions: WR_R → RX_L. In mono, the right slot is skipped, so WR_L → RX_L at the next falling edge.
- Byte writes:
  - Low byte at addr, high byte at addr+1, on consecutive cycles.
  - The address increments after every byte.
  - A stereo frame takes 4 bytes; a mono frame takes 2.
- Half complete (the write of byte address 2^BUFFER_ADDR_BITS−1):
  - If filled_o is low: toggle sel_o, set filled_o, address wraps to 0.
  - If filled_o is high: set overrun_o, do not toggle sel_o, address wraps to 0 and the same half is overwritten.
- Handshake: taken_i while filled_o is high clears filled_o on the next cycle. taken_i while filled_o is low is ignored.
- Simultaneous half complete and taken_i: the taken is processed first, so the swap happens and filled_o stays high. No overrun.
- Enable handling:
  - enable_i is sampled only at frame boundaries (SYNC or the start of RX_L).
  - When enable drops, the current frame's writes complete, then the block returns to IDLE.
  - The partial half is discarded and the address is reset to 0 on the next enable. sel_o and filled_o are kept.
- Misaligned frame: an ADCLRCK edge arriving while still in WR_* → go to SYNC and drop that frame.
- Reset values: addr 0, wren 0, data 0, sel 0, filled 0, overrun 0, peak 0, state IDLE.
- overrun_o clears only on rst.

## Timing
- Input latency: aud_* pin change to the internal edge strobe is 3 clk cycles.
- Last data bit sampled → first wren pulse: 1 clk cycle.
- Second byte follows on the next cycle; the write phase of a stereo frame occupies ≤ 4 cycles per slot.
- Final byte write → sel_o/filled_o update: registered, same edge as the address wrap.
- taken_i → filled_o low: 1 cycle.
- Requires BCLK period ≥ 8 clk cycles.

## Configuration
- CAPTURE_PEAK_METER_EN defined:
  - Tracks the maximum |sample| over the current half. Negative full scale saturates to 0x7FFF.
  - On each half complete, latches its upper 8 bits to capture_peak_o, then restarts tracking.
- Not defined: the capture_peak_o port and all related logic are absent.

## Structure
- Shared package holds:
  - BUFFER_ADDR_BITS and SAMPLE_BITS defaults.
  - The capture state enum.
  - The mono channel-count constant (1).
- Sub-module i2s_rx_deserializer:
  - Contains the synchronizers, edge detect and shift register.
  - Outputs a one-cycle word_valid with the word and a channel flag.
- Top level holds the FSM, byte writer, buffer swap logic and peak meter.

## Test plan
- Stereo capture, left words 0x1234, right words 0xABCD → RAM bytes 34 12 CD AB repeating; filled_o rises after 128 frames with sel_o = 1.
- Mono capture (channels = 1), left 0x00FF → bytes FF 00; filled_o rises after 256 frames; right slots never written.
- No taken_i across two halves → overrun_o = 1, sel_o stays 1, filled_o stays 1; taken_i then clears filled_o only.
- Drop enable mid-frame → that frame's 4 bytes are written, then IDLE; on re-enable the first write is to address 0.
- rst asserted mid-half → all outputs return to reset values next cycle; capture restarts from SYNC.
- With CAPTURE_PEAK_METER_EN, samples in one half include 0x8000 and 0x4000 → capture_peak_o = 0x7F at swap.
